// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the program-loader state encoding.
// The instruction memory and its loader both size themselves from this package.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // The CPU stays in reset for the whole load and while a bad load is parked in ERR.
    function automatic logic holds_cpu(input loader_state_t s);
        logic hold;
        case (s)
            CNT_HI, CNT_LO, DATA, WRITE, ERR: hold = 1'b1;
            IDLE, DONE:                       hold = 1'b0;
            default:                          hold = 1'b0;
        endcase
        return hold;
    endfunction

    function automatic logic takes_bytes(input loader_state_t s);
        logic rdy;
        case (s)
            CNT_HI, CNT_LO, DATA: rdy = 1'b1;
            default:              rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host receiver plus the instruction-memory write port.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian word stream into instruction memory from address 0,
// holding the CPU in reset while the load runs.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int CW = ADDR_W + 1;
    localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

    loader_state_t     state_r;
    loader_state_t     state_nx_s;
    logic [7:0]        cnt_hi_r;
    logic [CW-1:0]     n_r;
    logic [CW-1:0]     addr_r;
    logic [1:0]        byte_idx_r;
    logic [23:0]       asm_r;
    logic              byte_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [31:0]       wr_data_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              err_r;

    logic              accept_s;
    logic [15:0]       count_s;
    logic              count_bad_s;
    logic              last_s;

    assign accept_s    = bus.byte_valid & byte_ready_r;
    assign count_s     = {cnt_hi_r, bus.byte_in};
    assign count_bad_s = (count_s == 16'd0) || ({1'b0, count_s} > DEPTH_17);
    // Word counter is one bit wider than the address so a full DEPTH load is representable.
    assign last_s      = (addr_r == (n_r - CW'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, ERR: begin
                if (start) state_nx_s = CNT_HI;
                else       state_nx_s = state_r;
            end
            CNT_HI: begin
                if (accept_s) state_nx_s = CNT_LO;
                else          state_nx_s = CNT_HI;
            end
            CNT_LO: begin
                if (!accept_s)       state_nx_s = CNT_LO;
                else if (count_bad_s) state_nx_s = ERR;
                else                 state_nx_s = DATA;
            end
            DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) state_nx_s = WRITE;
                else                                  state_nx_s = DATA;
            end
            WRITE: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = DATA;
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Count capture, byte assembly and address stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_hi_r   <= 8'd0;
            n_r        <= '0;
            addr_r     <= '0;
            byte_idx_r <= 2'd0;
            asm_r      <= 24'd0;
            wr_addr_r  <= '0;
            wr_data_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE, ERR: begin
                    if (start) begin
                        addr_r     <= '0;
                        byte_idx_r <= 2'd0;
                    end
                end
                CNT_HI: begin
                    if (accept_s) cnt_hi_r <= bus.byte_in;
                end
                CNT_LO: begin
                    if (accept_s) n_r <= count_s[CW-1:0];
                end
                DATA: begin
                    if (accept_s) begin
                        asm_r      <= {asm_r[15:0], bus.byte_in};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            wr_data_r <= {asm_r, bus.byte_in};
                            wr_addr_r <= addr_r[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (!last_s) addr_r <= addr_r + CW'(1);
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // Outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            byte_ready_r <= takes_bytes(state_nx_s);
            wr_en_r      <= (state_nx_s == WRITE);
            cpu_hold_r   <= holds_cpu(state_nx_s);
            done_r       <= (state_nx_s == DONE);
            err_r        <= (state_nx_s == ERR);
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign cpu_hold       = cpu_hold_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, gapped, error, full-depth and mid-load reset loads.
module tb_imem_loader;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    int n_checks = 0;
    int n_errors = 0;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(.ADDR_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [9:0]  wa_q [$];
    logic [31:0] wd_q [$];
    logic [31:0] words [0:1023];
    int          done_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/done monitor sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.wr_en === 1'b1) begin
                wa_q.push_back(bus.wr_addr);
                wd_q.push_back(bus.wr_data);
                check_val("ready_in_write", 32'(bus.byte_ready), 32'd0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                check_val("hold_in_done", 32'(cpu_hold), 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is consumed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic seen;
        int   k;
        bus.byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 50) begin
            seen = bus.byte_ready;
            @(negedge clk);
            k++;
        end
        if (!seen) check_val("byte_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_start(input logic [7:0] first_byte);
        wa_q.delete();
        wd_q.delete();
        done_cnt       = 0;
        start          = 1'b1;
        bus.byte_in    = first_byte;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("hold_rise", 32'(cpu_hold), 32'd1);
        check_val("err_clear", 32'(err), 32'd0);
    endtask

    // Streams the count then nbytes of data taken from words[].
    task automatic stream(input logic [15:0] n, input int nbytes, input bit gaps);
        int   gap;
        logic [31:0] w;
        pulse_start(n[15:8]);
        send_byte(n[15:8], 0);
        send_byte(n[7:0], gaps ? 1 : 0);
        for (int i = 0; i < nbytes; i++) begin
            w   = words[i / 4];
            gap = gaps ? ((i % 2) + int'($urandom_range(0, 2))) : 0;
            send_byte(w[31 - 8 * (i % 4) -: 8], gap);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic verify_writes(input int n, input string tag);
        repeat (4) @(negedge clk);
        check_val({tag, "_count"}, 32'(wa_q.size()), 32'(n));
        if (wa_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check_val({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
                check_val({tag, "_data"}, wd_q[i], words[i]);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        words[0] = 32'h2408_0005;
        words[1] = 32'hAC01_0000;
        words[2] = 32'h0123_4567;
        words[3] = 32'h89AB_CDEF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("rst_ready", 32'(bus.byte_ready), 32'd0);
        check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check_val("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check_val("rst_wr_data", bus.wr_data, 32'd0);
        check_val("rst_hold", 32'(cpu_hold), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);

        // Two-word load, continuous valid (byte offered during the start cycle too)
        stream(16'h0002, 8, 1'b0);
        check_val("hold_during_write", 32'(cpu_hold), 32'd1);
        verify_writes(2, "cont");
        check_val("cont_done", 32'(done_cnt), 32'd1);
        check_val("cont_hold_after", 32'(cpu_hold), 32'd0);

        // Same stream, gapped valid
        stream(16'h0002, 8, 1'b1);
        verify_writes(2, "gap");
        check_val("gap_done", 32'(done_cnt), 32'd1);

        // Zero count
        stream(16'h0000, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_val("zero_err", 32'(err), 32'd1);
        check_val("zero_hold", 32'(cpu_hold), 32'd1);
        check_val("zero_ready", 32'(bus.byte_ready), 32'd0);
        check_val("zero_writes", 32'(wa_q.size()), 32'd0);

        // Oversize count, issued from ERR
        stream(16'h0401, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_val("big_err", 32'(err), 32'd1);
        check_val("big_hold", 32'(cpu_hold), 32'd1);
        check_val("big_writes", 32'(wa_q.size()), 32'd0);

        // Recovery: one-word load out of ERR
        stream(16'h0001, 4, 1'b0);
        verify_writes(1, "recover");
        check_val("recover_done", 32'(done_cnt), 32'd1);
        check_val("recover_err", 32'(err), 32'd0);

        // Full-depth load
        for (int i = 0; i < 1024; i++) words[i] = (32'(i) * 32'h0001_0001) ^ 32'hDEAD_0000;
        stream(16'h0400, 4096, 1'b0);
        verify_writes(1024, "full");
        check_val("full_done", 32'(done_cnt), 32'd1);
        check_val("full_last_addr", 32'(bus.wr_addr), 32'h3FF);

        // Reset after 2nd byte of word 3
        stream(16'h0004, 10, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check_val("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
        check_val("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("mid_rst_writes", 32'(wa_q.size()), 32'd2);
        check_val("mid_rst_done", 32'(done_cnt), 32'd0);

        // Full reload restarts from address 0
        stream(16'h0004, 16, 1'b0);
        verify_writes(4, "reload");
        check_val("reload_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the CPU instruction memory from a byte stream. It is the write side of the instruction memory, which the fetch path only reads. It accepts a length-prefixed stream of big-endian MIPS words over a valid/ready byte handshake, writes each word to consecutive instruction-memory addresses from 0, and holds the CPU in reset while a load is in progress. It sits between the host serial receiver and the instruction-memory write port.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- DEPTH, 2**ADDR_W, maximum words per load
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address for the write
- wr_data  out  32  word to write
- cpu_hold  out  1  keeps the CPU in reset while high
- done  out  1  one-cycle pulse when a load completes successfully
- err  out  1  sticky error flag, cleared by the next accepted start

## Operation
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then N×4 data bytes. Each word is sent MSB first: byte0 → wr_data[31:24].
- States: IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0, cpu_hold=0. start → CNT_HI; cpu_hold rises, addr=0, byte index=0, err cleared.
- CNT_HI / CNT_LO: byte_ready=1. Each accepted byte (byte_valid&byte_ready) advances the state. After CNT_LO the count is checked:
  - N==0 or N>DEPTH → ERR.
  - Otherwise → DATA.
- DATA: byte_ready=1. Accepted bytes shift into a 32-bit assembly register. The 4th byte → WRITE.
- WRITE (one cycle): byte_ready=0, wr_en=1, wr_addr=addr, wr_data=assembled word.
  - If addr==N-1 → DONE.
  - Else addr+1 and → DATA.
- DONE (one cycle): done=1, cpu_hold=0, → IDLE.
- ERR: err=1, cpu_hold=1, byte_ready=0 (stream is not drained). Only start leaves ERR, going to CNT_HI with the same actions as from IDLE.
- start is ignored in CNT_HI, CNT_LO, DATA, WRITE and DONE.
- Arithmetic:
  - The word counter is ADDR_W+1 bits wide, so N==DEPTH is legal and address DEPTH-1 is the last one written.
  - wr_addr never wraps.
- Reset mid-load: everything returns to IDLE and cpu_hold=0. Words already written remain in memory; no partial-word write is issued.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0. State=IDLE.
- All outputs are registered, or decoded from registered state only. There is no combinational path from byte_valid to byte_ready.
- A byte is consumed on the rising edge where byte_valid&byte_ready=1. byte_valid may stay high across WRITE; the byte is held by the sender and taken in the next DATA cycle.
- Latency: wr_en is asserted in the cycle immediately after the edge that accepts a word's 4th byte. done is asserted in the cycle after the last WRITE.
- Sustained throughput: 4 bytes per 5 cycles.
- start and a byte_valid in the same IDLE cycle: the byte is not consumed (byte_ready=0 in IDLE).
- cpu_hold rises in the cycle after start is sampled and falls in the DONE cycle.

## Structure
- A shared package `imem_pkg` holds:
  - the state enum `loader_state_t`;
  - IMEM_ADDR_W=10;
  - IMEM_DEPTH.
  The instruction memory uses the same constants.
- Single module, no sub-module. The byte-assembly shift register and the counters are inline.

## Test plan
- Reset release, then idle for 10 cycles → all outputs 0, byte_ready=0.
- start; stream 00 02 24 08 00 05 AC 01 00 00 with continuous valid:
  - wr_en at addr 0 with 0x24080005;
  - wr_en at addr 1 with 0xAC010000;
  - one done pulse;
  - cpu_hold high from the cycle after start until DONE.
- Same stream with byte_valid toggling every other cycle plus random gaps → identical writes, no lost or duplicated bytes, byte_ready=0 on each WRITE cycle.
- Count 0x0000 → ERR, err=1, cpu_hold=1, no wr_en. Count 0x0401 → same. A new start then a valid 1-word load → err clears, the word is written at addr 0, done pulses.
- Count 0x0400 (DEPTH) with 4096 bytes → 1024 writes, last at wr_addr 0x3FF, done pulses, no wrap to 0.
- rst_n asserted after the 2nd byte of word 3 → immediate IDLE, cpu_hold=0, no further wr_en. A subsequent full load restarts at addr 0.
